// File: rtl/mux8to1_pkg.sv
// Shared constants and types for the registered 8-to-1 lane selector.
package mux8to1_pkg;

  localparam int NUM_LANES = 8;
  localparam int SEL_W     = 3;

  typedef logic [SEL_W-1:0] lane_idx_t;

endpackage

// File: rtl/mux8to1_reg_mux2_cell.sv
// Combinational 2:1 lane selector: y = a when s is 0, b when s is 1.
module mux2_cell #(
  parameter int LANE_W = 1
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              s,
  output logic [LANE_W-1:0] y
);

  always_comb begin
    y = a;
    if (s) begin
      y = b;
    end
  end

endmodule

// File: rtl/mux8to1_reg.sv
// Registered 8-to-1 lane selector: a three-level tree of 2:1 cells feeding
// an output register with a valid flag; Y holds whenever in_valid is low.
module mux8to1_reg
  import mux8to1_pkg::*;
#(
  parameter int LANE_W = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_LANES*LANE_W-1:0] D,
  input  lane_idx_t                   S,
  input  logic                        in_valid,
  output logic [LANE_W-1:0]           Y,
  output logic                        out_valid
);

  logic [NUM_LANES/2-1:0][LANE_W-1:0] lvl0;
  logic [NUM_LANES/4-1:0][LANE_W-1:0] lvl1;
  logic [LANE_W-1:0]                  sel;

  logic [LANE_W-1:0] y_d, y_q;
  logic              out_valid_d, out_valid_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES/2; gi++) begin : g_lvl0
      mux2_cell #(.LANE_W(LANE_W)) u_cell (
        .a (D[(2*gi)*LANE_W +: LANE_W]),
        .b (D[(2*gi+1)*LANE_W +: LANE_W]),
        .s (S[0]),
        .y (lvl0[gi])
      );
    end
    for (gi = 0; gi < NUM_LANES/4; gi++) begin : g_lvl1
      mux2_cell #(.LANE_W(LANE_W)) u_cell (
        .a (lvl0[2*gi]),
        .b (lvl0[2*gi+1]),
        .s (S[1]),
        .y (lvl1[gi])
      );
    end
  endgenerate

  mux2_cell #(.LANE_W(LANE_W)) u_lvl2 (
    .a (lvl1[0]),
    .b (lvl1[1]),
    .s (S[SEL_W-1]),
    .y (sel)
  );

  // The tree output is only consumed when in_valid is high, so an unknown
  // select on idle cycles never reaches the register.
  always_comb begin
    y_d         = y_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      y_d         = sel;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Y         = y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux8to1_reg.sv
// Self-checking bench for mux8to1_reg at LANE_W=1 and LANE_W=4, against a
// shift-and-mask lane model.
module tb_mux8to1_reg;

  logic        clk;
  logic        rst_n;
  logic [7:0]  d1;
  logic [31:0] d4;
  logic [2:0]  s;
  logic        in_valid;
  logic        y1;
  logic [3:0]  y4;
  logic        ov1, ov4;

  logic        exp1;
  logic [3:0]  exp4;
  logic        expv;

  int errors = 0;
  int checks = 0;

  mux8to1_reg #(.LANE_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .D(d1), .S(s), .in_valid(in_valid),
    .Y(y1), .out_valid(ov1)
  );

  mux8to1_reg #(.LANE_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .D(d4), .S(s), .in_valid(in_valid),
    .Y(y4), .out_valid(ov4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".y1"},  {31'd0, y1},  {31'd0, exp1});
    check({tag, ".y4"},  {28'd0, y4},  {28'd0, exp4});
    check({tag, ".ov1"}, {31'd0, ov1}, {31'd0, expv});
    check({tag, ".ov4"}, {31'd0, ov4}, {31'd0, expv});
  endtask

  // Drive one cycle of inputs, let an edge occur, update the model, check.
  task automatic cyc(input string tag, input logic [7:0] nd1, input logic [31:0] nd4,
                     input logic [2:0] ns, input logic nv);
    d1 = nd1; d4 = nd4; s = ns; in_valid = nv;
    @(posedge clk);
    if (nv) begin
      exp1 = nd1[int'(ns)];
      exp4 = 4'((nd4 >> (4 * int'(ns))) & 32'hF);
      expv = 1'b1;
    end else begin
      expv = 1'b0;
    end
    #1;
    check_all(tag);
    $display("txn %s d1=%h d4=%h s=%0d v=%0b -> y1=%0h y4=%0h ov=%0b",
             tag, nd1, nd4, ns, nv, y1, y4, ov1);
  endtask

  initial begin
    // Reset with no clock edge yet: outputs must already be zero.
    rst_n = 1'b0; d1 = 8'hFF; d4 = 32'h76543210; s = 3'd7; in_valid = 1'b1;
    exp1 = 1'b0; exp4 = 4'd0; expv = 1'b0;
    #2;
    check_all("reset");
    #1 rst_n = 1'b1;
    cyc("post_reset", 8'hFF, 32'h76543210, 3'd7, 1'b1);

    for (int k = 0; k < 8; k++) begin
      cyc($sformatf("sweep%0d", k), 8'b10101010, 32'h76543210, 3'(k), 1'b1);
      if (k == 4) begin
        // Pulse reset between edges.
        #2 rst_n = 1'b0;
        exp1 = 1'b0; exp4 = 4'd0; expv = 1'b0;
        #1;
        check_all("mid_reset");
        #1 rst_n = 1'b1;
      end
    end

    cyc("chg_s0", 8'b11001100, 32'h76543210, 3'd0, 1'b1);
    cyc("chg_s7", 8'b11001100, 32'h76543210, 3'd7, 1'b1);
    cyc("chg_s2", 8'b11001100, 32'h76543210, 3'd2, 1'b1);
    cyc("chg_s4", 8'b11001100, 32'h76543210, 3'd4, 1'b1);

    cyc("hold_cap", 8'hAA, 32'h76543210, 3'd1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc($sformatf("hold%0d", k), 8'h00, 32'h00000000, 3'd0, 1'b0);
    end
    cyc("hold_xsel", 8'h55, 32'hFEDCBA98, 3'bxxx, 1'b0);

    for (int k = 0; k < 40; k++) begin
      cyc($sformatf("rand%0d", k), 8'($urandom), 32'($urandom),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux8to1_reg.md
Name: mux8to1_reg

Overview:
- Registered 8-to-1 multiplexer built structurally from a tree of 2-to-1 mux cells.
- Selects one of eight data lanes by a 3-bit select and registers the result, giving one cycle of latency.
- Used as a lane-select element wherever a clean, glitch-free registered selection is needed. A valid flag travels alongside the data.

Parameters:
- LANE_W, 1, width in bits of each of the eight data lanes (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- D  input  8*LANE_W  data lanes; lane k = D[k*LANE_W +: LANE_W], lane 0 in the LSBs.
- S  input  3  lane select, unsigned 0..7.
- in_valid  input  1  qualifies D/S for capture this cycle.
- Y  output  LANE_W  registered selected lane.
- out_valid  output  1  Y updated on the last edge from a valid input.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - rst_n low forces Y = 0 and out_valid = 0 immediately, with no clock required.
  - Both outputs stay at 0 while rst_n is low.
  - Reset asserted mid-operation discards any pending value.
- Combinational path: sel = lane S of D, formed by a 3-level 2:1 tree.
  - Level 0: four cells select on S[0] across lane pairs (0,1), (2,3), (4,5), (6,7).
  - Level 1: two cells select on S[1].
  - Level 2: one cell selects on S[2].
  - Each cell outputs a when s = 0 and b when s = 1.
- Register, on each rising clk with rst_n high:
  - in_valid = 1: Y <= sel and out_valid <= 1.
  - in_valid = 0: Y holds its previous value and out_valid <= 0.
- Latency: exactly 1 cycle from a sampled (D, S, in_valid=1) to Y.
- Throughput: one selection per cycle; back-to-back valid inputs update Y every cycle.
- D or S changes while in_valid = 0 never affect Y.
- X/unknown on S while in_valid = 0 must not propagate into Y.
- Every S value 0..7 is legal; there are no out-of-range codes.
- First rising edge after reset release captures normally.

Decomposition:
- Package mux8to1_pkg:
  - constant NUM_LANES = 8.
  - constant SEL_W = 3.
  - lane index type sized by SEL_W.
- Sub-module mux2_cell (parameter LANE_W; ports a, b, s, y):
  - purely combinational.
  - instantiated 7 times in the tree.
- Top module holds only the tree wiring and the output register.

Test Plan:
- Reset check: assert rst_n=0 with D=8'hFF, S=7, in_valid=1, no clock edges -> Y=0, out_valid=0 immediately. Release reset, one edge -> Y=1, out_valid=1.
- Full select sweep, LANE_W=1: D=8'b10101010, in_valid=1, S=0..7 on successive cycles -> Y one cycle later = 0,1,0,1,0,1,0,1 and out_valid=1 throughout.
- Data change: D=8'b11001100, S=0 -> Y=0. Then S=7 -> Y=1. Then S=2 -> Y=1. Then S=4 -> Y=0.
- Hold: capture S=1 with D=8'hAA (Y=1), then in_valid=0, D=8'h00, S=0 for 3 cycles -> Y stays 1 and out_valid=0.
- Async reset mid-stream: during the sweep, pulse rst_n low between edges -> Y and out_valid drop to 0 at once. The next valid capture after release resumes correctly.
- Wide lanes, LANE_W=4: D=32'h76543210, S=k -> Y=k for k = 0..7.
